uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, configurable frame format (data bits, parity, stop bits) and a valid/ready write handshake. It is the next-generation serial TX used by the board-level test designs. Producers push bytes without polling `busy`, and frames are emitted back-to-back with no idle gap while the FIFO holds data.

## Interface
- `BAUD_RATE`, default 9_600: line bit rate.
- `SYS_CLK_FREQ`, default 48_000_000: `clk` frequency in Hz.
  - BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE, integer division.
  - BIT_PERIOD must be ≥ 2.
- `DATA_BITS`, default 8: data bits per frame, legal range 5..8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.
- `FIFO_DEPTH`, default 16: entry count, power of 2, ≥ 2.
- `clk`  in  1  system clock; the block has one clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `data_in`  in  DATA_BITS  word to enqueue.
- `valid_in`  in  1  `data_in` valid.
- `ready_out`  out  1  FIFO can accept a word.
- `tx`  out  1  UART line, registered, idles high.
- `busy`  out  1  frame in progress or FIFO non-empty.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of occupied FIFO entries.

## Operation
- **Write handshake:** a word is written on any rising edge where `valid_in && ready_out`.
  - `ready_out` = registered !full, computed from the count after that edge's write and pop.
  - No combinational path runs from `valid_in` to `ready_out`.
- **No bypass:** every word passes through the FIFO.
- **FSM states:** IDLE → START → DATA → [PARITY] → STOP → IDLE, or STOP → START directly.
- **IDLE:**
  - `tx` = 1.
  - If the FIFO is non-empty: pop into the shifter, drive `tx` = 0 on the same edge, load timer = BIT_PERIOD-1, go to START.
- **START:** hold for BIT_PERIOD cycles, then go to DATA with bit index 0.
- **DATA:**
  - Send LSB first, each bit for BIT_PERIOD cycles.
  - After bit DATA_BITS-1: go to PARITY if PARITY≠0, else STOP.
- **PARITY:** one bit period.
  - Even parity bit = XOR of data bits.
  - Odd parity bit = inverted XOR of data bits.
- **STOP:** `tx` = 1 for STOP_BITS×BIT_PERIOD cycles.
  - On the final cycle, if the FIFO is non-empty: pop and go to START (`tx` = 0 next cycle, zero idle gap).
  - Otherwise go to IDLE.
- **Frame length:** (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BIT_PERIOD cycles, exact.
- **Timer:** width $clog2(BIT_PERIOD), down-counter, reloads at each bit boundary.
- **`busy`:** (state≠IDLE) || (fifo_count≠0), registered.
- **Boundary cases:**
  - Full FIFO with a pop on the same edge: the write is still refused, because `ready_out` was low.
  - Empty FIFO with a write: no pop that edge; the pop happens on the following edge.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous write and pop: `fifo_count` is unchanged.

## Timing
- **Reset** (`reset_n` low at an edge):
  - Outputs: `tx`=1, `busy`=0, `ready_out`=0, `fifo_count`=0.
  - Internals: FSM=IDLE, FIFO pointers cleared.
  - `ready_out` rises on the first edge with `reset_n` high.
- **Reset mid-frame:** aborts the frame. `tx` returns to 1 at that edge and FIFO contents are discarded.
- **Latency:** word written at edge E0 into an empty FIFO with FSM in IDLE:
  - E1: pop.
  - `tx` low from E1.
  - `busy` high from E1, i.e. the cycle after the write.
  - `fifo_count` reads 1 after E0 and 0 after E1.
- **Stop bit:** the last stop bit ends exactly frame-length cycles after `tx` fell.
- **Writes during transmission:** allowed, and do not perturb the bit timing.

## Configuration
- **`UART_TX_BREAK_EN` defined:**
  - Adds input `send_break` (1 bit).
  - While `send_break` is high and the FSM is in IDLE, `tx` is driven 0 and no pop occurs. A frame in progress completes first.
  - After `send_break` falls, `tx` = 1 for exactly one BIT_PERIOD (mark-after-break) before any frame may start.
  - FIFO writes remain accepted during break.
- **`UART_TX_BREAK_EN` undefined:** the port is absent, and IDLE behaves as described under Operation.

## Test plan
Bench parameters for all scenarios: SYS_CLK_FREQ=1_000_000, BAUD_RATE=100_000 (BIT_PERIOD=10).
- **Reset:** hold `reset_n`=0 for 5 cycles.
  - `tx`=1, `busy`=0, `ready_out`=0, `fifo_count`=0.
  - `ready_out`=1 one cycle after release.
- **8N1 frame:** write 0xA5.
  - `tx` falls one cycle after the write.
  - Sampled line bits, 10 cycles each: 0, 1,0,1,0,0,1,0,1, 1.
  - Frame is 100 cycles, then `busy`=0.
- **7E2 frame:** DATA_BITS=7, PARITY=2, STOP_BITS=2; write 0x31 (three ones).
  - Parity bit=1.
  - Frame is 110 cycles; the last 20 cycles are high.
- **Back-to-back and full FIFO:** FIFO_DEPTH=4; hold `valid_in` high with 0x01..0x06.
  - Exactly 5 words accepted: 1 popped immediately, then 4 queued, then `ready_out`=0.
  - Five frames with zero idle cycles between stop and start bits.
  - Order of received words is preserved.
- **Reset mid-frame:** assert `reset_n`=0 at cycle 35 of a frame with 2 words queued.
  - `tx`=1 at the next edge.
  - `fifo_count`=0, and no further frames.
- **Break (macro on):** `send_break` high for 50 cycles while idle.
  - `tx` low for 50 cycles, then high for 10 cycles.
  - A queued 0x55 then starts its start bit.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake bundle for uart_tx_fifo: one word moves on a rising edge with valid_in && ready_out.
// Latency: none, plain wiring.
// Backpressure: the consumer lowers ready_out when it cannot take a word.
// Signals: data_in (word), valid_in (producer has a word), ready_out (consumer can accept).
// Modports: master = producer side, slave = uart_tx_fifo side.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] data_in;
  logic                 valid_in;
  logic                 ready_out;

  modport master (output data_in, output valid_in, input ready_out);
  modport slave  (input data_in, input valid_in, output ready_out);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frames (DATA_BITS, PARITY, STOP_BITS) go out back-to-back while words are queued.
// Latency: a word written into an empty FIFO while idle pops on the next edge, and tx falls on that same edge.
// Backpressure: ready_out is registered !full; a word offered while ready_out is low is not taken.
// Ports: clk, reset_n (synchronous, active low), wr (uart_tx_fifo_if.slave: data_in/valid_in/ready_out),
//        tx (registered line, idles high), busy (registered: frame active or FIFO non-empty), fifo_count.
// Optional: UART_TX_BREAK_EN adds send_break (line held low while idle, then one bit of mark before the next frame).
module uart_tx_fifo #(
  parameter int BAUD_RATE    = 9_600,
  parameter int SYS_CLK_FREQ = 48_000_000,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              clk,
  input  logic                              reset_n,
`ifdef UART_TX_BREAK_EN
  input  logic                              send_break,
`endif
  uart_tx_fifo_if.slave                     wr,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
  localparam int TW         = $clog2(BIT_PERIOD);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CW         = $clog2(FIFO_DEPTH + 1);

  localparam logic [TW-1:0] T_RELOAD  = TW'(BIT_PERIOD - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  // Odd parity is the inverted XOR of the data bits.
  localparam logic          PAR_INV   = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count, count_nxt;
  logic                 wr_en, pop, fifo_ne, idle_hold, last_stop;

  // Serialiser state
  state_t               state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

`ifdef UART_TX_BREAK_EN
  // mab: mark-after-break in progress; timer counts it down while idle.
  logic                 mab;
  assign idle_hold = send_break || mab;
`else
  assign idle_hold = 1'b0;
`endif

  assign wr_en      = wr.valid_in && wr.ready_out;
  assign fifo_ne    = (count != '0);
  assign fifo_count = count;
  assign last_stop  = (state == S_STOP) && (timer == '0) && (bit_idx == LAST_STOP);
  // Pops only look at the registered count, so a word written into an empty FIFO pops one edge later.
  assign pop        = fifo_ne && (((state == S_IDLE) && !idle_hold) || last_stop);

  always_comb begin
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr.data_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      wr.ready_out <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count        <= count_nxt;
      wr.ready_out <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      mab     <= 1'b0;
`endif
    end else begin
      busy <= (state != S_IDLE) || fifo_ne;
      if (pop) begin
        // Covers both the idle start and the zero-gap restart from the last stop cycle.
        shreg   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ PAR_INV;
        tx      <= 1'b0;
        timer   <= T_RELOAD;
        state   <= S_START;
      end else begin
        case (state)
          S_IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (send_break) begin
              tx    <= 1'b0;
              mab   <= 1'b1;
              timer <= T_RELOAD;
            end else if (mab) begin
              tx <= 1'b1;
              if (timer == '0) mab   <= 1'b0;
              else             timer <= timer - 1'b1;
            end else begin
              tx <= 1'b1;
            end
`else
            tx <= 1'b1;
`endif
          end
          S_START: begin
            if (timer == '0) begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= '0;
              timer   <= T_RELOAD;
              state   <= S_DATA;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_DATA: begin
            if (timer == '0) begin
              timer <= T_RELOAD;
              if (bit_idx == LAST_DATA) begin
                bit_idx <= '0;
                if (PARITY != 0) begin
                  tx    <= par_bit;
                  state <= S_PARITY;
                end else begin
                  tx    <= 1'b1;
                  state <= S_STOP;
                end
              end else begin
                tx      <= shreg[0];
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 1'b1;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_PARITY: begin
            if (timer == '0) begin
              tx      <= 1'b1;
              bit_idx <= '0;
              timer   <= T_RELOAD;
              state   <= S_STOP;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          S_STOP: begin
            if (timer == '0) begin
              // The restart case of the final stop cycle is taken by the pop branch above.
              if (bit_idx == LAST_STOP) begin
                state <= S_IDLE;
              end else begin
                bit_idx <= bit_idx + 1'b1;
                timer   <= T_RELOAD;
              end
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 16, 7E2 depth 16, 8N1 depth 4) at BIT_PERIOD = 10.
// Line activity of each instance is logged per cycle and decoded into frames, which are compared
// against words queued in a scoreboard when they were written.
module tb_uart_tx_fifo;

  localparam int LOGN = 4096;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic [4:0] cnt_a, cnt_b;
  logic [2:0] cnt_c;

  logic log_a [LOGN];
  logic log_b [LOGN];
  logic log_c [LOGN];

  logic [7:0] sb_a [$];
  logic [7:0] sb_b [$];
  logic [7:0] sb_c [$];

  uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
  uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
  uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();

`ifdef UART_TX_BREAK_EN
  logic brk_a = 1'b0;
  logic brk_b = 1'b0;
  logic brk_c = 1'b0;
`endif

  uart_tx_fifo #(.BAUD_RATE(100_000), .SYS_CLK_FREQ(1_000_000)) u_a (
    .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk_a),
`endif
    .wr(if_a), .tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

  uart_tx_fifo #(.BAUD_RATE(100_000), .SYS_CLK_FREQ(1_000_000),
                 .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_b (
    .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk_b),
`endif
    .wr(if_b), .tx(tx_b), .busy(busy_b), .fifo_count(cnt_b));

  uart_tx_fifo #(.BAUD_RATE(100_000), .SYS_CLK_FREQ(1_000_000), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .reset_n(reset_n),
`ifdef UART_TX_BREAK_EN
    .send_break(brk_c),
`endif
    .wr(if_c), .tx(tx_c), .busy(busy_c), .fifo_count(cnt_c));

  always #5 clk = ~clk;

  // cyc = number of rising edges so far; log[k] holds the line value after edge k.
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_a[cyc] <= tx_a;
      log_b[cyc] <= tx_b;
      log_c[cyc] <= tx_c;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic lg(input int which, input int i);
    if (i < 0 || i >= LOGN) return 1'bx;
    case (which)
      0:       return log_a[i];
      1:       return log_b[i];
      default: return log_c[i];
    endcase
  endfunction

  function automatic int find_fall(input int which, input int from, input int to);
    for (int i = from; i <= to; i++)
      if (i >= 1 && lg(which, i) === 1'b0 && lg(which, i - 1) === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_val(input int which, input int from, input int to, input logic v);
    int n = 0;
    for (int i = from; i <= to; i++)
      if (lg(which, i) === v) n++;
    return n;
  endfunction

  // Decodes a frame starting at log index s: each bit must hold for 10 cycles,
  // start must be 0 and every stop bit 1 for ok to stay set.
  function automatic void decode(input int which, input int s, input int nd, input int np,
                                 input int ns, output logic [7:0] data, output logic par,
                                 output logic ok);
    int   nbits;
    logic b;
    nbits = 1 + nd + np + ns;
    data  = '0;
    par   = 1'b0;
    ok    = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      b = lg(which, s + 10 * k);
      for (int j = 1; j < 10; j++)
        if (lg(which, s + 10 * k + j) !== b) ok = 1'b0;
      if (k == 0) begin
        if (b !== 1'b0) ok = 1'b0;
      end else if (k <= nd) begin
        data[k-1] = b;
      end else if (np != 0 && k == nd + 1) begin
        par = b;
      end else if (b !== 1'b1) begin
        ok = 1'b0;
      end
    end
  endfunction

  function automatic logic [7:0] pop_exp(input int which);
    case (which)
      0:       if (sb_a.size() != 0) return sb_a.pop_front();
      1:       if (sb_b.size() != 0) return sb_b.pop_front();
      default: if (sb_c.size() != 0) return sb_c.pop_front();
    endcase
    return 8'hxx;
  endfunction

  initial begin
    logic [7:0] got, expw;
    logic       par, ok;
    int         s, e0, fall;
`ifdef UART_TX_BREAK_EN
    int         b0;
`endif

    reset_n = 1'b0;
    if_a.valid_in = 1'b0; if_a.data_in = '0;
    if_b.valid_in = 1'b0; if_b.data_in = '0;
    if_c.valid_in = 1'b0; if_c.data_in = '0;

    // Reset
    repeat (5) step();
    check("rst_tx", tx_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_ready", if_a.ready_out, 0);
    check("rst_count", cnt_a, 0);
    check("rst_count_c", cnt_c, 0);
    reset_n = 1'b1;
    step();
    check("rst_ready_rise", if_a.ready_out, 1);
    check("rst_ready_rise_c", if_c.ready_out, 1);

    // 8N1 single frame, 0xA5
    if_a.data_in = 8'hA5; if_a.valid_in = 1'b1; sb_a.push_back(8'hA5);
    step();
    e0 = cyc;
    if_a.valid_in = 1'b0;
    check("a_cnt_after_wr", cnt_a, 1);
    check("a_tx_idle_at_wr", tx_a, 1);
    step();
    check("a_tx_fall_lat", tx_a, 0);
    check("a_busy_lat", busy_a, 1);
    check("a_cnt_after_pop", cnt_a, 0);
    repeat (110) step();
    s = find_fall(0, e0, e0 + 5);
    check("a_fall_edge", s, e0 + 1);
    decode(0, s, 8, 0, 1, got, par, ok);
    check("a_frame_shape", ok, 1);
    expw = pop_exp(0);
    check("a_data", got, expw);
    check("a_idle_after_100", lg(0, s + 100), 1);
    check("a_busy_end", busy_a, 0);

    // 7E2: 0x31 (odd number of ones) then 0x03 (even), back-to-back
    if_b.data_in = 7'h31; if_b.valid_in = 1'b1; sb_b.push_back(8'h31);
    step();
    e0 = cyc;
    if_b.data_in = 7'h03; sb_b.push_back(8'h03);
    step();
    if_b.valid_in = 1'b0;
    repeat (240) step();
    s = find_fall(1, e0, e0 + 5);
    check("b_fall_edge", s, e0 + 1);
    for (int f = 0; f < 2; f++) begin
      decode(1, s + 110 * f, 7, 1, 2, got, par, ok);
      expw = pop_exp(1);
      check($sformatf("b_frame_shape_%0d", f), ok, 1);
      check($sformatf("b_data_%0d", f), got, expw);
      check($sformatf("b_parity_%0d", f), par, ^expw[6:0]);
    end
    check("b_idle_after", lg(1, s + 220), 1);
    check("b_busy_end", busy_b, 0);

    // Depth-4 FIFO, valid held high with 0x01..0x06
    for (int k = 1; k <= 12; k++) begin
      if_c.data_in = 8'((k <= 6) ? k : 6);
      if_c.valid_in = 1'b1;
      if (k <= 5) sb_c.push_back(8'(k));
      step();
      if (k == 1) e0 = cyc;
      check($sformatf("c_ready_%0d", k), if_c.ready_out, (k <= 4) ? 1 : 0);
      check($sformatf("c_count_%0d", k), cnt_c, (k == 1) ? 1 : ((k <= 5) ? k - 1 : 4));
    end
    if_c.valid_in = 1'b0;
    repeat (520) step();
    s = find_fall(2, e0, e0 + 5);
    check("c_fall_edge", s, e0 + 1);
    for (int f = 0; f < 5; f++) begin
      decode(2, s + 100 * f, 8, 0, 1, got, par, ok);
      expw = pop_exp(2);
      check($sformatf("c_frame_shape_%0d", f), ok, 1);
      check($sformatf("c_data_%0d", f), got, expw);
    end
    check("c_sb_empty", sb_c.size(), 0);
    check("c_no_sixth", find_fall(2, s + 500, cyc - 1), -1);
    check("c_count_end", cnt_c, 0);
    check("c_busy_end", busy_c, 0);

    // Reset mid-frame with two words queued
    for (int k = 0; k < 3; k++) begin
      if_a.data_in = 8'(8'h11 * (k + 1));
      if_a.valid_in = 1'b1;
      step();
      if (k == 0) e0 = cyc;
    end
    if_a.valid_in = 1'b0;
    check("rm_queued", cnt_a, 2);
    s = find_fall(0, e0, e0 + 5);
    check("rm_fall_edge", s, e0 + 1);
    while (cyc < s + 34) step();
    check("rm_tx_low_before", tx_a, 0);
    reset_n = 1'b0;
    step();
    check("rm_tx", tx_a, 1);
    check("rm_count", cnt_a, 0);
    check("rm_busy", busy_a, 0);
    reset_n = 1'b1;
    repeat (150) step();
    fall = find_fall(0, s + 36, cyc - 1);
    check("rm_no_frames", fall, -1);
    check("rm_count_end", cnt_a, 0);
    check("rm_busy_end", busy_a, 0);

`ifdef UART_TX_BREAK_EN
    // Break for 50 cycles with 0x55 queued during it
    brk_a = 1'b1;
    if_a.data_in = 8'h55; if_a.valid_in = 1'b1; sb_a.push_back(8'h55);
    b0 = cyc;
    step();
    if_a.valid_in = 1'b0;
    check("brk_write_held", cnt_a, 1);
    while (cyc < b0 + 50) step();
    brk_a = 1'b0;
    repeat (130) step();
    check("brk_low_cycles", count_val(0, b0 + 1, b0 + 50, 1'b0), 50);
    check("brk_mark_cycles", count_val(0, b0 + 51, b0 + 60, 1'b1), 10);
    s = find_fall(0, b0 + 51, b0 + 80);
    check("brk_start_edge", s, b0 + 61);
    decode(0, s, 8, 0, 1, got, par, ok);
    expw = pop_exp(0);
    check("brk_frame_shape", ok, 1);
    check("brk_data", got, expw);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
